// File: rtl/gf2m_pkg.sv
// Shared constants, FSM state type and sizing helper for the GF(2^m) digit-serial multiplier.
package gf2m_pkg;

    localparam logic [162:0] B163_POLY = 163'hC9;
    localparam logic [7:0]   AES_POLY  = 8'h1B;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        REDUCE,
        DONE
    } state_t;

    function automatic int unsigned calc_ndig(input int unsigned m, input int unsigned d);
        return (m + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2m_digit_serial_mult_clmul.sv
// Combinational D x M carry-less multiply of one A digit against the full B operand.
module gf2_digit_clmul #(
    parameter int unsigned D = 8,
    parameter int unsigned M = 163
) (
    input  logic [D-1:0]   digit,
    input  logic [M-1:0]   b,
    output logic [D+M-2:0] prod
);

    localparam int unsigned PW = D + M - 1;

    always_comb begin
        prod = '0;
        for (int unsigned j = 0; j < D; j++) begin
            if (digit[j]) begin
                prod = prod ^ (PW'(b) << j);
            end
        end
    end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2)[x] multiplier with optional one-cycle reduction modulo x^M + POLY.
module gf2m_digit_serial_mult
    import gf2m_pkg::*;
#(
    parameter int unsigned   M    = 163,
    parameter int unsigned   D    = 8,
    parameter logic [M-1:0]  POLY = M'(B163_POLY)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    input  logic           reduce_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*M-2:0] c,
    output logic           busy
);

    localparam int unsigned NDIG = calc_ndig(M, D);
    localparam int unsigned AW   = 2 * M - 1;
    localparam int unsigned PW   = D + M - 1;
    localparam int unsigned PADW = NDIG * D;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    state_t        state, next_state;
    logic [M-1:0]  a_reg, b_reg;
    logic          red_reg;
    logic [AW-1:0] acc, acc_next;
    logic [CW-1:0] cnt;
    logic [PADW-1:0] a_pad;
    logic [D-1:0]  digit;
    logic [PW-1:0] prod;
    int unsigned   shamt;

    // Folds every bit above M-1 back in, top bit first, so later folds see earlier contributions.
    function automatic logic [M-1:0] reduce_poly(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        logic [AW-1:0] f;
        r = v;
        f = AW'({1'b1, POLY});
        for (int unsigned k = AW - 1; k >= M; k--) begin
            if (r[k]) begin
                r = r ^ (f << (k - M));
            end
        end
        return r[M-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = MULT;
            MULT:    if (cnt == CW'(NDIG - 1)) next_state = REDUCE;
            REDUCE:  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // The final partial digit reads zeros above bit M-1 from the padded copy of A.
    always_comb begin
        a_pad    = PADW'(a_reg);
        shamt    = 32'(cnt) * D;
        digit    = a_pad[shamt +: D];
        acc_next = acc ^ (AW'(prod) << shamt);
    end

    gf2_digit_clmul #(
        .D(D),
        .M(M)
    ) u_clmul (
        .digit(digit),
        .b    (b_reg),
        .prod (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            red_reg <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            c       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        red_reg <= reduce_en;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                MULT: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
                REDUCE: begin
                    c <= red_reg ? AW'(reduce_poly(acc)) : acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Directed and reference-model checks for the digit-serial GF(2^m) multiplier, two configurations.
module tb_gf2m_digit_serial_mult;
    import gf2m_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         big_in_valid, big_in_ready, big_red, big_out_valid, big_out_ready, big_busy;
    logic [162:0] big_a, big_b;
    logic [324:0] big_c;

    logic         sm_in_valid, sm_in_ready, sm_red, sm_out_valid, sm_out_ready, sm_busy;
    logic [7:0]   sm_a, sm_b;
    logic [14:0]  sm_c;

    int n_checks = 0;
    int n_errors = 0;

    gf2m_digit_serial_mult #(.M(163), .D(8), .POLY(B163_POLY)) u_big (
        .clk(clk), .rst(rst), .in_valid(big_in_valid), .in_ready(big_in_ready),
        .a(big_a), .b(big_b), .reduce_en(big_red), .out_valid(big_out_valid),
        .out_ready(big_out_ready), .c(big_c), .busy(big_busy)
    );

    gf2m_digit_serial_mult #(.M(8), .D(3), .POLY(AES_POLY)) u_sm (
        .clk(clk), .rst(rst), .in_valid(sm_in_valid), .in_ready(sm_in_ready),
        .a(sm_a), .b(sm_b), .reduce_en(sm_red), .out_valid(sm_out_valid),
        .out_ready(sm_out_ready), .c(sm_c), .busy(sm_busy)
    );

    task automatic check(input string tag, input logic [324:0] got, input logic [324:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [324:0] clmul_ref(input logic [162:0] x, input logic [162:0] y, input int m);
        logic [324:0] r;
        r = '0;
        for (int i = 0; i < m; i++) if (x[i]) r = r ^ (325'(y) << i);
        return r;
    endfunction

    function automatic logic [324:0] mod_ref(input logic [324:0] v, input int m, input logic [162:0] poly);
        logic [324:0] f;
        f = (325'(1) << m) | 325'(poly);
        for (int k = 2 * m - 2; k >= m; k--) if (v[k]) v = v ^ (f << (k - m));
        return v & ((325'(1) << m) - 325'(1));
    endfunction

    function automatic logic [162:0] rand163();
        return 163'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic start_big(input logic [162:0] x, input logic [162:0] y, input logic r);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!big_in_ready && guard < 100) begin @(negedge clk); guard++; end
        big_a = x; big_b = y; big_red = r; big_in_valid = 1'b1;
        @(negedge clk);
        big_in_valid = 1'b0; big_a = '1; big_b = '1; big_red = ~r;
    endtask

    // lat counts edges with the accept edge as 1; hs_ok drops if busy/in_ready misbehave while waiting.
    task automatic wait_big(output int lat, output logic hs_ok);
        lat = 1; hs_ok = 1'b1;
        while (!big_out_valid && lat < 200) begin
            if (!big_busy || big_in_ready) hs_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_big(input logic [162:0] x, input logic [162:0] y, input logic r,
                           output logic [324:0] res, output int lat, output logic hs_ok);
        start_big(x, y, r);
        wait_big(lat, hs_ok);
        res = big_c;
        big_out_ready = 1'b1;
        @(negedge clk);
        big_out_ready = 1'b0;
    endtask

    task automatic run_sm(input logic [7:0] x, input logic [7:0] y, input logic r,
                          output logic [14:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!sm_in_ready && guard < 100) begin @(negedge clk); guard++; end
        sm_a = x; sm_b = y; sm_red = r; sm_in_valid = 1'b1;
        @(negedge clk);
        sm_in_valid = 1'b0; sm_a = ~x; sm_b = ~y;
        lat = 1;
        while (!sm_out_valid && lat < 200) begin @(negedge clk); lat++; end
        res = sm_c;
        sm_out_ready = 1'b1;
        @(negedge clk);
        sm_out_ready = 1'b0;
    endtask

    initial begin
        logic [324:0] res, exp;
        logic [14:0]  sres;
        logic [162:0] x, y;
        logic [7:0]   sx, sy;
        logic         hs_ok;
        int           lat;

        rst = 1'b1;
        big_in_valid = 1'b0; big_a = '0; big_b = '0; big_red = 1'b0; big_out_ready = 1'b0;
        sm_in_valid = 1'b0; sm_a = '0; sm_b = '0; sm_red = 1'b0; sm_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 325'(big_in_ready), 325'(1));
        check("rst_out_valid", 325'(big_out_valid), 325'(0));
        check("rst_busy", 325'(big_busy), 325'(0));
        check("rst_c", big_c, '0);
        check("rst_sm_c", 325'(sm_c), '0);
        rst = 1'b0;

        run_big(163'd1, 163'd1, 1'b1, res, lat, hs_ok);
        check("one_c", res, 325'd1);
        check("one_lat", 325'(lat), 325'd23);
        check("one_busy_hs", 325'(hs_ok), 325'd1);
        check("one_idle_ready", 325'(big_in_ready), 325'd1);
        check("one_idle_valid", 325'(big_out_valid), 325'd0);

        run_big(163'd1 << 162, 163'd2, 1'b1, res, lat, hs_ok);
        check("x163_mod", res, 325'h0C9);
        run_big(163'd1 << 162, 163'd2, 1'b0, res, lat, hs_ok);
        check("x163_full", res, 325'd1 << 163);
        run_big(163'd1 << 162, 163'd1 << 162, 1'b0, res, lat, hs_ok);
        check("x324_full", res, 325'd1 << 324);
        run_big(163'd3, 163'd3, 1'b0, res, lat, hs_ok);
        check("three_sq", res, 325'd5);

        run_sm(8'h53, 8'hCA, 1'b1, sres, lat);
        check("aes_inv", 325'(sres), 325'h01);
        check("aes_lat", 325'(lat), 325'd5);
        run_sm(8'h57, 8'h83, 1'b1, sres, lat);
        check("aes_57_83", 325'(sres), 325'hC1);
        run_sm(8'h57, 8'h83, 1'b0, sres, lat);
        check("aes_57_83_full", 325'(sres), 325'h2B79);

        // back-pressure: result must hold and in_valid pulses must not be taken
        start_big(163'd3, 163'd3, 1'b1);
        wait_big(lat, hs_ok);
        check("bp_lat", 325'(lat), 325'd23);
        for (int i = 0; i < 10; i++) begin
            big_in_valid = 1'b1; big_a = rand163(); big_b = rand163();
            @(negedge clk);
            check("bp_valid", 325'(big_out_valid), 325'd1);
            check("bp_c", big_c, 325'd5);
            check("bp_in_ready", 325'(big_in_ready), 325'd0);
        end
        big_in_valid = 1'b0;
        big_out_ready = 1'b1;
        @(negedge clk);
        big_out_ready = 1'b0;
        check("bp_rel_ready", 325'(big_in_ready), 325'd1);
        check("bp_rel_valid", 325'(big_out_valid), 325'd0);
        check("bp_c_kept", big_c, 325'd5);
        @(negedge clk);
        check("bp_no_accept", 325'(big_busy), 325'd0);

        // abort while digit 5 is being processed
        start_big(rand163(), rand163(), 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 325'(big_out_valid), 325'd0);
        check("abort_ready", 325'(big_in_ready), 325'd1);
        check("abort_c", big_c, '0);
        check("abort_busy", 325'(big_busy), 325'd0);

        for (int i = 0; i < 1000; i++) begin
            x = rand163(); y = rand163();
            run_big(x, y, 1'(i % 2), res, lat, hs_ok);
            exp = clmul_ref(x, y, 163);
            if (i % 2 == 1) exp = mod_ref(exp, 163, B163_POLY);
            check("rand_big", res, exp);
            check("rand_big_lat", 325'(lat), 325'd23);
        end

        for (int i = 0; i < 200; i++) begin
            sx = 8'($urandom()); sy = 8'($urandom());
            run_sm(sx, sy, 1'(i % 2), sres, lat);
            exp = clmul_ref(163'(sx), 163'(sy), 8);
            if (i % 2 == 1) exp = mod_ref(exp, 8, 163'(AES_POLY));
            check("rand_sm", 325'(sres), exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
